count_display: RTL and testbench
================================

// Module: count_display
// PURPOSE
//  Reader/display end of the 8-bit user count bus. Samples count[7:0] from the
//  counter, converts it to BCD with a sequential double-dabble engine, and
//  time-multiplexes the digits onto a 4-digit common-anode 7-segment display.
//  Sits between the counter block and the board display pins, on Clk100M.
// PARAMETERS
//  CLK_HZ      100_000_000  input clock frequency
//  DIGIT_HZ    1_000        per-digit refresh rate; scan tick every CLK_HZ/(DIGIT_HZ*4) clocks
//  LZ_BLANK    1            1 = blank leading zeros (units digit always lit)
// PORTS
//  Clk100M    in   1  system clock, all logic on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  count      in   8  unsigned count from counter block; may change on any cycle
//  an         out  4  digit anodes, active-low; an[0] = units
//  seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp         out  1  decimal point, active-low; always 1 (off)
//  busy       out  1  high while a BCD conversion is in flight
// BEHAVIOUR
//  Reset: asynchronous, active-low. an=4'b1111, seg=7'h7F, dp=1, busy=0,
//   displayed BCD={0,0,0}, last_cnv=0, scan index=0, prescaler=0.
//  Conversion FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
//   IDLE: if count != last_cnv, latch count into shift reg and last_cnv, busy=1, go SHIFT.
//   SHIFT: 8 iterations; each: add 3 to any BCD nibble >=5, then shift left 1.
//   COMMIT: copy hundreds/tens/units to display regs in one cycle, busy=0, go IDLE.
//   Latency: count change to display regs updated = 10 clocks (1 latch + 8 + 1).
//  count changes while busy are ignored until IDLE; then re-compared, so the
//   display always settles on the final stable value within 20 clocks.
//  Display regs change only in COMMIT: no partially-converted digits are shown.
//  Scan: prescaler counts 0..CLK_HZ/(DIGIT_HZ*4)-1, tick on terminal count.
//   On tick, scan index advances 0->1->2->3->0 (wraps). Exactly one an bit is low.
//   Digit 3 is always blank (seg=7'h7F) since max value 255.
//   LZ_BLANK=1: hundreds blank if 0; tens blank if hundreds and tens both 0.
//  Outputs registered: an/seg change on the clock after the tick.
//  Encoding: 0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19 5=7'h12 6=7'h02 7=7'h78
//   8=7'h00 9=7'h10; any nibble >9 (must not occur) -> 7'h7F.
//  Reset mid-conversion: abort, all state back to reset values; first post-reset
//   scan shows "0" on digit 0 (no conversion needed since last_cnv=count=0).
// STRUCTURE
//  Package count_display_pkg: SEG_* segment constants, function seg_decode(nibble),
//   NUM_DIGITS=4, state enum {IDLE,SHIFT,COMMIT}.
//  Sub-module bin2bcd_seq: start/count in, busy/done/bcd[11:0] out; owns the
//   shift/add-3 engine. Top holds compare, display regs, prescaler, scan mux.
// TESTING (bench uses DIGIT_HZ so tick period = 4 clocks)
//  Reset with count=0 -> an=1111, seg=7F during reset; after first tick
//   an=1110, seg=7'h40; digits 1..3 blank.
//  count 0->255 -> busy high 9 clocks; 10 clocks later display regs 2/5/5;
//   scan shows 7'h12,7'h12,7'h24, digit 3 blank.
//  count=7 then 107 (LZ_BLANK=1) -> 7: tens/hundreds blank; 107: tens shows 7'h40.
//  count 10->200 three clocks into conversion of 10 -> shows 10 first,
//   then 200 within 20 clocks of the change; no other value ever committed.
//  rst_n low mid-SHIFT for count=128 -> busy=0, an=1111 immediately (async);
//   after release, reconverts and shows 128.
//  Run 4 ticks -> an sequence 1110,1101,1011,0111,1110 (wrap), one-hot-low each.

Source files
------------

// File: rtl/count_display_pkg.sv
// Shared types, segment constants and the BCD-nibble
// to 7-segment decoder for the count display.
package count_display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } cnv_state_e;

  function automatic logic [6:0] seg_decode(
    input logic [3:0] n
  );
    logic [6:0] s;
    case (n)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/count_display_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift
// iteration per clock, result held through COMMIT.
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [11:0] bcd_o
);

  cnv_state_e  state_q, state_d;
  logic [19:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] adj;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_q[8+4*i +: 4] >= 4'd5)
        adj[8+4*i +: 4] = sr_q[8+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sr_d    = {12'd0, bin_i};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {adj[18:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7)
          state_d = COMMIT;
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == COMMIT);
  assign bcd_o  = sr_q[19:8];

endmodule

// File: rtl/count_display.sv
// Count bus reader: BCD conversion plus
// multiplexed 4-digit common-anode display.
module count_display
  import count_display_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIGIT_HZ = 1_000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic       Clk100M,
  input  logic       rst_n,
  input  logic [7:0] count,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int TICK_DIV = CLK_HZ / (DIGIT_HZ * NUM_DIGITS);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [7:0]    last_q;
  logic [11:0]   disp_q;
  logic [PW-1:0] ps_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  logic          cnv_busy;
  logic          cnv_done;
  logic [11:0]   cnv_bcd;
  logic          start;
  logic          tick;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic [3:0]    hun, ten, unt;

  // Only re-sample the bus once the engine is free again
  assign start = !cnv_busy && (count != last_q);
  assign tick  = (ps_q == PS_LAST);

  bin2bcd_seq u_bcd (
    .clk_i   (Clk100M),
    .rst_ni  (rst_n),
    .start_i (start),
    .bin_i   (count),
    .busy_o  (cnv_busy),
    .done_o  (cnv_done),
    .bcd_o   (cnv_bcd)
  );

  assign hun = disp_q[11:8];
  assign ten = disp_q[7:4];
  assign unt = disp_q[3:0];

  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = SEG_BLANK;
    case (idx_q)
      2'd0: seg_d = seg_decode(unt);
      2'd1: seg_d = (LZ_BLANK && hun == 4'd0 && ten == 4'd0)
                    ? SEG_BLANK : seg_decode(ten);
      2'd2: seg_d = (LZ_BLANK && hun == 4'd0)
                    ? SEG_BLANK : seg_decode(hun);
      default: seg_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge Clk100M or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      disp_q <= '0;
      ps_q   <= '0;
      idx_q  <= '0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_BLANK;
    end else begin
      if (start)
        last_q <= count;
      if (cnv_done)
        disp_q <= cnv_bcd;
      ps_q <= tick ? '0 : ps_q + 1'b1;
      if (tick) begin
        an_q  <= an_d;
        seg_q <= seg_d;
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = cnv_busy;

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with a
// 4-clock scan tick.
module tb_count_display;

  typedef struct {
    logic [7:0] cnt;
    logic [6:0] d0;
    logic [6:0] d1;
    logic [6:0] d2;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] count;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] cap [4];
  logic       anbad;
  vec_t       tbl [9];

  count_display #(
    .CLK_HZ   (100_000_000),
    .DIGIT_HZ (6_250_000),
    .LZ_BLANK (1'b1)
  ) dut (
    .Clk100M (clk),
    .rst_n   (rst_n),
    .count   (count),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic capture();
    for (int i = 0; i < 4; i++) cap[i] = 7'bx;
    anbad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: cap[0] = seg;
        4'b1101: cap[1] = seg;
        4'b1011: cap[2] = seg;
        4'b0111: cap[3] = seg;
        default: anbad = 1'b1;
      endcase
    end
  endtask

  task automatic scan_check(input string nm,
                            input logic [6:0] e0,
                            input logic [6:0] e1,
                            input logic [6:0] e2);
    capture();
    chk({nm, " an onehot"}, {31'd0, anbad}, 32'd0);
    chk({nm, " d0"}, {25'd0, cap[0]}, {25'd0, e0});
    chk({nm, " d1"}, {25'd0, cap[1]}, {25'd0, e1});
    chk({nm, " d2"}, {25'd0, cap[2]}, {25'd0, e2});
    chk({nm, " d3"}, {25'd0, cap[3]}, 32'h7F);
  endtask

  initial begin
    logic       bad;
    logic       settle_bad;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    tbl[0] = '{8'd255, 7'h12, 7'h12, 7'h24};
    tbl[1] = '{8'd7,   7'h78, 7'h7F, 7'h7F};
    tbl[2] = '{8'd107, 7'h78, 7'h40, 7'h79};
    tbl[3] = '{8'd0,   7'h40, 7'h7F, 7'h7F};
    tbl[4] = '{8'd10,  7'h40, 7'h79, 7'h7F};
    tbl[5] = '{8'd200, 7'h40, 7'h40, 7'h24};
    tbl[6] = '{8'd128, 7'h00, 7'h24, 7'h79};
    tbl[7] = '{8'd99,  7'h10, 7'h10, 7'h7F};
    tbl[8] = '{8'd100, 7'h40, 7'h40, 7'h79};

    rst_n = 1'b0;
    count = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst an",   {28'd0, an},  32'hF);
    chk("rst seg",  {25'd0, seg}, 32'h7F);
    chk("rst dp",   {31'd0, dp},  32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) chk("pre-tick an", {28'd0, an}, 32'hF);
      if (k % 4 == 0) begin
        case (k)
          4, 20:   exp_an = 4'b1110;
          8:       exp_an = 4'b1101;
          12:      exp_an = 4'b1011;
          default: exp_an = 4'b0111;
        endcase
        exp_seg = (exp_an == 4'b1110) ? 7'h40 : 7'h7F;
        chk($sformatf("tick%0d an", k / 4),
            {28'd0, an}, {28'd0, exp_an});
        chk($sformatf("tick%0d seg", k / 4),
            {25'd0, seg}, {25'd0, exp_seg});
      end
    end

    @(negedge clk);
    count = 8'd255;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("busy clk%0d", k), {31'd0, busy},
          (k <= 9) ? 32'd1 : 32'd0);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      count = tbl[i].cnt;
      repeat (14) @(posedge clk);
      scan_check($sformatf("vec %0d", tbl[i].cnt),
                 tbl[i].d0, tbl[i].d1, tbl[i].d2);
    end

    // 100 shown; change to 10, then 200 mid-conversion
    @(negedge clk);
    count = 8'd10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    count = 8'd200;
    bad = 1'b0;
    settle_bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      case (an)
        4'b1110: if (seg !== 7'h40) bad = 1'b1;
        4'b1101: if (seg !== 7'h40 && seg !== 7'h79) bad = 1'b1;
        4'b1011: if (seg !== 7'h79 && seg !== 7'h7F &&
                     seg !== 7'h24) bad = 1'b1;
        4'b0111: if (seg !== 7'h7F) bad = 1'b1;
        default: bad = 1'b1;
      endcase
      if (k >= 20 && busy !== 1'b0) settle_bad = 1'b1;
    end
    chk("10->200 digits", {31'd0, bad}, 32'd0);
    chk("10->200 settle", {31'd0, settle_bad}, 32'd0);
    scan_check("final 200", 7'h40, 7'h40, 7'h24);

    @(negedge clk);
    count = 8'd128;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst an",   {28'd0, an},  32'hF);
    chk("midrst seg",  {25'd0, seg}, 32'h7F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    scan_check("post-rst 128", 7'h00, 7'h24, 7'h79);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
